// File: rtl/xc_wb_pkg.sv
// Shared types and widths for the writeback arbiter and its scoreboard.
package xc_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
endpackage

// File: rtl/xc_wb_scoreboard.sv
// Pending-write busy vector for coprocessor results, with three read ports
// (two decode sources plus the port A destination used for WAW blocking).
module xc_wb_scoreboard
  import xc_wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic              set_wide,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic              clr_wide,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] conf_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              conf_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) begin
      set_mask[set_addr] = 1'b1;
      if (set_wide) set_mask[set_addr | REG_AW'(1)] = 1'b1;
    end
    if (clr_en) begin
      clr_mask[clr_addr] = 1'b1;
      if (clr_wide) clr_mask[clr_addr | REG_AW'(1)] = 1'b1;
    end
    // x0 never has a pending write
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_mask) | set_mask;
  end

  assign rs1_busy  = busy[rs1_addr];
  assign rs2_busy  = busy[rs2_addr];
  assign conf_busy = busy[conf_addr];

endmodule

// File: rtl/xc_wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline (A) and the crypto
// coprocessor (B) onto the single register-file write port.
module xc_wb_arbiter
  import xc_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [XLEN-1:0]   a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wide,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [XLEN-1:0]   b_wdata,
  input  logic [XLEN-1:0]   b_wdata_hi,
  input  logic              iss_valid,
  input  logic              iss_wide,
  input  logic [REG_AW-1:0] iss_addr,
  input  logic [REG_AW-1:0] hz_rs1_addr,
  input  logic [REG_AW-1:0] hz_rs2_addr,
  output logic              hz_rs1_busy,
  output logic              hz_rs2_busy,
  output logic              rd_wen,
  output logic              rd_wide,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_wdata,
  output logic [XLEN-1:0]   rd_wdata_hi,
  output logic              err_misalign
);

  logic [CNT_W-1:0] starve_cnt;
  logic             bstarve;
  logic             a_busy;
  logic             a_conf;
  logic             b_misalign;
  src_t             sel;

  xc_wb_scoreboard u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_en    (iss_valid),
    .set_wide  (iss_wide),
    .set_addr  (iss_addr),
    .clr_en    (b_ready),
    .clr_wide  (b_wide),
    .clr_addr  (b_addr),
    .rs1_addr  (hz_rs1_addr),
    .rs2_addr  (hz_rs2_addr),
    .conf_addr (a_addr),
    .rs1_busy  (hz_rs1_busy),
    .rs2_busy  (hz_rs2_busy),
    .conf_busy (a_busy)
  );

  assign bstarve    = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign a_conf     = a_busy && (a_addr != '0);
  assign b_ready    = b_valid && (!a_valid || a_conf || bstarve);
  assign a_ready    = a_valid && !a_conf && !b_ready;
  assign sel        = b_ready ? SRC_B : SRC_A;
  assign b_misalign = b_wide && b_addr[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (b_valid && !b_ready) begin
      if (starve_cnt != {CNT_W{1'b1}}) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Output stage: accepted result appears on the write port one edge later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_wen       <= 1'b0;
      rd_wide      <= 1'b0;
      rd_addr      <= '0;
      rd_wdata     <= '0;
      rd_wdata_hi  <= '0;
      err_misalign <= 1'b0;
    end else begin
      rd_wen       <= 1'b0;
      err_misalign <= 1'b0;
      if (a_ready || b_ready) begin
        if (sel == SRC_A) begin
          rd_wen   <= (a_addr != '0);
          rd_wide  <= 1'b0;
          rd_addr  <= a_addr;
          rd_wdata <= a_wdata;
        end else if (b_misalign) begin
          err_misalign <= 1'b1;
        end else begin
          // a wide pair at x0 is legal: the register file ignores x0, writes x1
          rd_wen      <= b_wide || (b_addr != '0);
          rd_wide     <= b_wide;
          rd_addr     <= b_addr;
          rd_wdata    <= b_wdata;
          if (b_wide) rd_wdata_hi <= b_wdata_hi;
        end
      end
    end
  end

endmodule

// File: tb/tb_xc_wb_arbiter.sv
// Directed bench for xc_wb_arbiter: arbitration, starvation, scoreboard and reset.
module tb_xc_wb_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 0, b_valid = 0, b_wide = 0, iss_valid = 0, iss_wide = 0;
  logic [4:0]  a_addr = 0, b_addr = 0, iss_addr = 0, hz_rs1_addr = 0, hz_rs2_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0, b_wdata_hi = 0;
  logic        a_ready, b_ready, hz_rs1_busy, hz_rs2_busy, rd_wen, rd_wide, err_misalign;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata, rd_wdata_hi;

  int checks = 0;
  int errors = 0;

  xc_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wide(b_wide), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_wdata_hi(b_wdata_hi),
    .iss_valid(iss_valid), .iss_wide(iss_wide), .iss_addr(iss_addr),
    .hz_rs1_addr(hz_rs1_addr), .hz_rs2_addr(hz_rs2_addr),
    .hz_rs1_busy(hz_rs1_busy), .hz_rs2_busy(hz_rs2_busy),
    .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
    .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi), .err_misalign(err_misalign)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #2;
    check("rst_wen", rd_wen, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_wdata", rd_wdata, 0);
    check("rst_err", err_misalign, 0);
    check("rst_aready", a_ready, 0);
    @(negedge clock);
    reset = 1'b0;

    // 1: single A write
    a_valid = 1; a_addr = 5; a_wdata = 32'h1234;
    settle();
    check("t1_aready", a_ready, 1);
    check("t1_bready", b_ready, 0);
    tick();
    a_valid = 0;
    check("t1_wen", rd_wen, 1);
    check("t1_addr", rd_addr, 5);
    check("t1_wdata", rd_wdata, 32'h1234);
    check("t1_wide", rd_wide, 0);
    tick();
    check("t1_wen_off", rd_wen, 0);
    check("t1_addr_hold", rd_addr, 5);

    // 2: wide issue to x6/x7, then wide B result
    iss_valid = 1; iss_wide = 1; iss_addr = 6;
    tick();
    iss_valid = 0; iss_wide = 0;
    hz_rs1_addr = 6; hz_rs2_addr = 7;
    settle();
    check("t2_hz1_set", hz_rs1_busy, 1);
    check("t2_hz2_set", hz_rs2_busy, 1);
    b_valid = 1; b_wide = 1; b_addr = 6; b_wdata = 32'hAAAA; b_wdata_hi = 32'hBBBB;
    settle();
    check("t2_bready", b_ready, 1);
    check("t2_hz1_pre", hz_rs1_busy, 1);
    tick();
    b_valid = 0; b_wide = 0;
    settle();
    check("t2_wen", rd_wen, 1);
    check("t2_wide", rd_wide, 1);
    check("t2_addr", rd_addr, 6);
    check("t2_wdata", rd_wdata, 32'hAAAA);
    check("t2_wdata_hi", rd_wdata_hi, 32'hBBBB);
    check("t2_hz1_clr", hz_rs1_busy, 0);
    check("t2_hz2_clr", hz_rs2_busy, 0);

    // 3: starvation, A wins 4 cycles then B takes the 5th
    a_valid = 1; a_addr = 3; a_wdata = 32'h33;
    b_valid = 1; b_addr = 9; b_wdata = 32'h99;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("t3_aready", a_ready, 1);
      check("t3_bready", b_ready, 0);
      tick();
      check("t3_a_addr", rd_addr, 3);
    end
    check("t3_aready_starved", a_ready, 0);
    check("t3_bready_starved", b_ready, 1);
    tick();
    b_valid = 0;
    settle();
    check("t3_b_addr", rd_addr, 9);
    check("t3_b_wdata", rd_wdata, 32'h99);
    check("t3_aready_resume", a_ready, 1);
    tick();
    a_valid = 0;
    check("t3_a_again", rd_addr, 3);

    // 4: WAW block on x10 until B drains it
    iss_valid = 1; iss_addr = 10;
    tick();
    iss_valid = 0;
    a_valid = 1; a_addr = 10; a_wdata = 32'hA0;
    settle();
    check("t4_ablock0", a_ready, 0);
    tick();
    check("t4_ablock1", a_ready, 0);
    check("t4_nowen", rd_wen, 0);
    b_valid = 1; b_addr = 10; b_wdata = 32'hB0;
    settle();
    check("t4_bready", b_ready, 1);
    check("t4_ablock2", a_ready, 0);
    tick();
    b_valid = 0;
    settle();
    check("t4_b_wen", rd_wen, 1);
    check("t4_b_wdata", rd_wdata, 32'hB0);
    check("t4_aready", a_ready, 1);
    tick();
    a_valid = 0;
    check("t4_a_wen", rd_wen, 1);
    check("t4_a_wdata", rd_wdata, 32'hA0);

    // 5: misaligned wide B result
    b_valid = 1; b_wide = 1; b_addr = 7; b_wdata = 32'hDEAD; b_wdata_hi = 32'hBEEF;
    settle();
    check("t5_bready", b_ready, 1);
    tick();
    b_valid = 0; b_wide = 0;
    check("t5_nowen", rd_wen, 0);
    check("t5_err", err_misalign, 1);
    check("t5_hi_hold", rd_wdata_hi, 32'hBBBB);
    tick();
    check("t5_err_off", err_misalign, 0);

    // x0 handling: A to x0 never writes; wide pair at x0 busies/writes x1 only
    a_valid = 1; a_addr = 0; a_wdata = 32'h77;
    settle();
    check("x0_aready", a_ready, 1);
    tick();
    a_valid = 0;
    check("x0_nowen", rd_wen, 0);
    iss_valid = 1; iss_wide = 1; iss_addr = 0;
    tick();
    iss_valid = 0; iss_wide = 0;
    hz_rs1_addr = 0; hz_rs2_addr = 1;
    settle();
    check("x0_hz0", hz_rs1_busy, 0);
    check("x0_hz1", hz_rs2_busy, 1);
    b_valid = 1; b_wide = 1; b_addr = 0; b_wdata = 32'h10; b_wdata_hi = 32'h11;
    tick();
    b_valid = 0; b_wide = 0;
    settle();
    check("x0_wide_wen", rd_wen, 1);
    check("x0_wide_hi", rd_wdata_hi, 32'h11);
    check("x0_hz1_clr", hz_rs2_busy, 0);

    // 6: reset right after a B accept while x12 is busy
    iss_valid = 1; iss_addr = 12;
    tick();
    iss_valid = 0;
    hz_rs1_addr = 12;
    b_valid = 1; b_addr = 13; b_wdata = 32'hC0;
    settle();
    check("t6_hz_busy", hz_rs1_busy, 1);
    tick();
    b_valid = 0;
    check("t6_wen_pre", rd_wen, 1);
    reset = 1;
    settle();
    check("t6_wen_rst", rd_wen, 0);
    check("t6_hz_rst", hz_rs1_busy, 0);
    check("t6_addr_rst", rd_addr, 0);
    @(negedge clock);
    reset = 0;
    tick();
    check("t6_nowen", rd_wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xc_wb_arbiter.md
Name: xc_wb_arbiter

Overview:
- Writeback stage directly upstream of the odd/even-banked 2R1W register file.
- Merges two result producers into the single register-file write port:
  - port A: in-order pipeline, single-width results.
  - port B: multi-cycle crypto coprocessor, single- or double-width results.
- Keeps a pending-write scoreboard for port B issues and exposes hazard flags to decode.
- Drives the register-file write port (rd_wen/rd_wide/rd_addr/rd_wdata/rd_wdata_hi) from registers.

Parameters:
STARVE_LIMIT, 4, consecutive cycles port B may wait with b_valid high before it takes priority over A (1..2^CNT_W-1)
CNT_W, 3, width of the B starvation counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
a_valid  in  1  port A result valid
a_ready  out  1  port A result accepted this cycle
a_addr  in  5  port A destination register
a_wdata  in  32  port A result
b_valid  in  1  port B result valid
b_ready  out  1  port B result accepted this cycle
b_wide  in  1  port B result is a register pair
b_addr  in  5  port B destination (even if b_wide)
b_wdata  in  32  port B low/only word
b_wdata_hi  in  32  port B high word (to b_addr|1)
iss_valid  in  1  coprocessor instruction issued, mark destination busy
iss_wide  in  1  issued instruction writes a pair
iss_addr  in  5  issued destination
hz_rs1_addr  in  5  decode source 1
hz_rs2_addr  in  5  decode source 2
hz_rs1_busy  out  1  source 1 has a pending B write
hz_rs2_busy  out  1  source 2 has a pending B write
rd_wen  out  1  register-file write enable
rd_wide  out  1  register-file pair write
rd_addr  out  5  register-file write address
rd_wdata  out  32  register-file low/only data
rd_wdata_hi  out  32  register-file high data
err_misalign  out  1  one-cycle pulse: B wide result with odd b_addr, dropped

Behaviour:
- Reset (async, immediate): all rd_* outputs 0, err_misalign 0, busy vector 0, starvation counter 0. a_ready/b_ready are combinational and follow the rules below with busy=0.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each cycle b_valid && !b_ready.
  - Clears on B accept or when b_valid is low.
  - bstarve = (counter >= STARVE_LIMIT).
- Arbitration (combinational), with a_conf = busy[a_addr] && a_addr!=0:
  - b_ready = b_valid && (!a_valid || a_conf || bstarve).
  - a_ready = a_valid && !a_conf && !b_ready.
  - At most one accept per cycle.
- Accept -> write latency is exactly 1 cycle. On the clock edge after an accept, the rd_* registers load the accepted result and rd_wen=1. Otherwise rd_wen=0 and the other rd_* fields hold.
- Port A write: rd_wide=0, rd_addr=a_addr, rd_wdata=a_wdata. a_addr=0 is accepted but rd_wen stays 0.
- Port B narrow write: as port A, using b_addr/b_wdata.
- Port B wide write:
  - rd_wide=1, rd_addr=b_addr, rd_wdata=b_wdata, rd_wdata_hi=b_wdata_hi.
  - b_addr[0]=1 is illegal: accepted, no write, err_misalign=1 for one cycle; busy bits still cleared.
  - Wide write to b_addr=0 is legal; only x1 changes in the register file.
- Scoreboard (32-bit busy register):
  - Set: iss_valid sets busy[iss_addr], and busy[iss_addr|1] when iss_wide. Bit 0 is never set.
  - Clear: a B accept clears busy[b_addr], and busy[b_addr|1] when b_wide. Clear happens on the same edge that loads rd_*.
  - Set and clear of the same bit in one cycle: set wins.
- Hazard flags: hz_rsN_busy = busy[hz_rsN_addr], combinational from the registered vector. Address 0 always reads 0.
- Port A is blocked (WAW) while its destination has a pending B write. B can still drain because a_conf grants B.
- Reset asserted mid-transfer: the pending write is lost and the scoreboard is cleared; the upstream units are reset by the same signal.

Decomposition:
- Shared package xc_wb_pkg:
  - XLEN=32, REG_AW=5.
  - Source encoding SRC_A/SRC_B (1 bit) for the registered source tag.
- One natural sub-module: xc_wb_scoreboard, holding the busy vector, the set/clear logic and the two hazard read ports.
- Arbitration, starvation counter and output registers live in the top module.

Test Plan:
1. Reset then a_valid, a_addr=5, a_wdata=0x1234, b_valid=0 -> a_ready=1; next cycle rd_wen=1, rd_addr=5, rd_wdata=0x1234, rd_wide=0.
2. iss_valid, iss_wide=1, iss_addr=6; then b_valid, b_wide=1, b_addr=6, data 0xAAAA/0xBBBB with a_valid=0 -> busy[6],busy[7] read 1 via hz flags until the accept edge; next cycle rd_wen=1, rd_wide=1, rd_addr=6, rd_wdata_hi=0xBBBB; flags return to 0.
3. a_valid and b_valid both held continuously (A to x3, B to x9), STARVE_LIMIT=4 -> A accepted for 4 cycles, B accepted on the 5th cycle with a_ready=0, then A resumes.
4. iss_valid to x10, then a_valid with a_addr=10 -> a_ready=0 until the B result for x10 is accepted; A is accepted the cycle after that, so its write lands after B's.
5. b_valid, b_wide=1, b_addr=7 -> b_ready=1, rd_wen stays 0, err_misalign pulses high for exactly one cycle.
6. Assert reset in the cycle after a B accept with busy[12]=1 -> rd_wen=0 immediately, hz_rs1_busy (rs1=12)=0, no write occurs.
